// File: rtl/quadrature_pkg.sv
// Shared state encodings, quadrature phase constants and phase helpers
// for the quadrature generator and the matching decoder benches.
package quadrature_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_EDGE = 2'd2
    } state_t;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_01 = 2'b01;

    localparam int TIMER_W = 8;

    // Forward order is 00->10->11->01->00; reverse walks it backwards.
    function automatic logic [1:0] phase_step(input logic [1:0] ph, input logic rev);
        logic [1:0] nxt;
        nxt = PH_00;
        case (ph)
            PH_00:   nxt = rev ? PH_01 : PH_10;
            PH_10:   nxt = rev ? PH_00 : PH_11;
            PH_11:   nxt = rev ? PH_10 : PH_01;
            PH_01:   nxt = rev ? PH_11 : PH_00;
            default: nxt = PH_00;
        endcase
        return nxt;
    endfunction

    function automatic logic is_detent(input logic [1:0] ph);
        return (ph == PH_00) || (ph == PH_11);
    endfunction

endpackage

// File: rtl/quadrature_gen_edge_timer.sv
// Reloadable down-counter that sets the spacing between quadrature edges.
// expire is high during the last cycle of a loaded period.
module edge_timer
    import quadrature_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expire
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = value;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == W'(1));

endmodule

// File: rtl/quadrature_gen.sv
// Quadrature a/b generator that walks position toward a latched target,
// one count (two edges, detent to detent) at a time.
module quadrature_gen
    import quadrature_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int INCREMENT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] target,
    input  logic             load,
    input  logic [7:0]       interval,
    output logic             a,
    output logic             b,
    output logic [WIDTH-1:0] position,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INCREMENT);

    state_t               state_q, state_d;
    logic [1:0]           phase_q, phase_d;
    logic [WIDTH-1:0]     pos_q, pos_d;
    logic [WIDTH-1:0]     target_q, target_d;
    logic                 dir_q, dir_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [WIDTH-1:0]     tgt_eff;
    logic [WIDTH-1:0]     diff;
    logic [WIDTH-1:0]     diff_mag;
    logic                 diff_neg;
    logic                 far;
    logic                 at_detent;
    logic                 stop;
    logic                 start;
    logic                 emit;
    logic                 dir_use;
    logic                 tmr_load;
    logic                 tmr_expire;
    logic [TIMER_W-1:0]   tmr_value;

    // A load in the current cycle is seen immediately so a retarget never
    // lets a stale target end the move.
    always_comb begin
        tgt_eff   = load ? target : target_q;
        diff      = tgt_eff - pos_q;
        diff_neg  = diff[WIDTH-1];
        diff_mag  = diff_neg ? ('0 - diff) : diff;
        far       = (diff_mag >= INC_W);
        at_detent = is_detent(phase_q);
        stop      = at_detent && !far;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (load && far) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD, ST_EDGE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (tmr_expire) begin
                    state_d = ST_EDGE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The edge is registered on the clock that enters EDGE, so with a
    // one-cycle interval EDGE simply repeats and edges land on every clock.
    always_comb begin
        start     = (state_q == ST_IDLE) && load && far;
        emit      = (state_q != ST_IDLE) && !stop && tmr_expire;
        tmr_load  = emit || start;
        tmr_value = (interval == 8'd0) ? 8'd1 : interval;
        dir_use   = at_detent ? diff_neg : dir_q;

        phase_d  = phase_q;
        pos_d    = pos_q;
        dir_d    = dir_q;
        target_d = load ? target : target_q;

        if (emit) begin
            phase_d = phase_step(phase_q, dir_use);
            if (at_detent) begin
                dir_d = diff_neg;
                pos_d = diff_neg ? (pos_q - INC_W) : (pos_q + INC_W);
            end
        end

        busy_d = (state_d != ST_IDLE);
        done_d = ((state_q != ST_IDLE) && (state_d == ST_IDLE))
              || ((state_q == ST_IDLE) && load && !far);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q  <= PH_00;
            pos_q    <= '0;
            target_q <= '0;
            dir_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            pos_q    <= pos_d;
            target_q <= target_d;
            dir_q    <= dir_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    edge_timer #(
        .W (TIMER_W)
    ) u_edge_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (tmr_load),
        .value  (tmr_value),
        .expire (tmr_expire)
    );

    assign a        = phase_q[1];
    assign b        = phase_q[0];
    assign position = pos_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
